retire_trace_emitter: RTL and testbench

- Hardware producer for the per-cycle retirement log of the pipelined MIPS-Lite core.
- Each cycle it samples the WB-stage retirement info (PC, instruction word, write data, bubble flag) and decodes the instruction into a mnemonic class code.
- It stamps each record with a cycle index and buffers it in a FIFO.
- Records stream out on a valid/ready interface to a trace sink (UART bridge, logger, or bench checker) instead of being printed by the bench.

---
 rtl/mips_trace_pkg.sv | 55 +++++
 rtl/trace_fifo.sv | 84 ++++++++
 rtl/retire_trace_emitter.sv | 148 ++++++++++++++
 tb/tb_retire_trace_emitter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg
//   Shared constants for the MIPS-Lite retirement trace path:
//   - record field widths (PC, instruction, write data, class code)
//   - 5-bit mnemonic class codes carried in each trace record
//   - opcode / funct encodings recognised by the class decoder
//   No ports; imported by retire_trace_emitter and trace_fifo.
package mips_trace_pkg;

  // Record field widths
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int WD_W    = 32;
  localparam int CLASS_W = 5;

  // Mnemonic class codes
  localparam logic [CLASS_W-1:0] CL_NOP     = 5'd0;
  localparam logic [CLASS_W-1:0] CL_ADD     = 5'd1;
  localparam logic [CLASS_W-1:0] CL_SUB     = 5'd2;
  localparam logic [CLASS_W-1:0] CL_AND     = 5'd3;
  localparam logic [CLASS_W-1:0] CL_OR      = 5'd4;
  localparam logic [CLASS_W-1:0] CL_SLT     = 5'd5;
  localparam logic [CLASS_W-1:0] CL_MULTU   = 5'd6;
  localparam logic [CLASS_W-1:0] CL_MFHI    = 5'd7;
  localparam logic [CLASS_W-1:0] CL_MFLO    = 5'd8;
  localparam logic [CLASS_W-1:0] CL_SRL     = 5'd9;
  localparam logic [CLASS_W-1:0] CL_BUBBLE  = 5'd10;
  localparam logic [CLASS_W-1:0] CL_LW      = 5'd11;
  localparam logic [CLASS_W-1:0] CL_SW      = 5'd12;
  localparam logic [CLASS_W-1:0] CL_BEQ     = 5'd13;
  localparam logic [CLASS_W-1:0] CL_J       = 5'd14;
  localparam logic [CLASS_W-1:0] CL_ADDIU   = 5'd15;
  localparam logic [CLASS_W-1:0] CL_MADDU   = 5'd16;
  localparam logic [CLASS_W-1:0] CL_UNKNOWN = 5'd31;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_MADDU = 6'd28;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is presented
//   combinationally on rdata whenever empty=0.
//   Ports:
//     clk, rst     posedge clock, synchronous active-high reset (empties FIFO)
//     push, wdata  write request and data; accepted if not full or popping
//     pop          remove head entry; ignored when empty
//     rdata        head entry (undefined content when empty)
//     full, empty  occupancy flags
//     level        occupancy 0..DEPTH
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the level MSB alone marks "full".
  assign full  = level_q[AW];
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the write pointer targets
  // (wr_ptr == rd_ptr), so the incoming word can land in the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; stale contents are never visible because
  // the top gates every output field with empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/retire_trace_emitter.sv
// retire_trace_emitter
//   Samples the WB-stage retirement slot each cycle, decodes a mnemonic
//   class, stamps the record with a cycle index and buffers it in a FWFT
//   FIFO that drains to a trace sink.
//   Ports:
//     clk, rst                posedge clock, synchronous active-high reset
//     ret_valid/pc/instr/wd   retirement slot presented this cycle
//     ret_bubble              slot is a hazard-inserted bubble
//     trc_valid, trc_ready    output handshake: a record transfers on a
//                             cycle where both are 1; while trc_valid=1 and
//                             trc_ready=0 every trc_* field holds stable, and
//                             trc_valid never drops without a transfer
//                             (except on rst)
//     trc_cycle/pc/class/wd   head record fields (0 when trc_valid=0)
//     fifo_level              FIFO occupancy 0..DEPTH
//     drop_count              records lost to overflow, saturating
module retire_trace_emitter
  import mips_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ret_valid,
  input  logic [31:0]            ret_pc,
  input  logic [31:0]            ret_instr,
  input  logic [31:0]            ret_wd,
  input  logic                   ret_bubble,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [CNT_W-1:0]       trc_cycle,
  output logic [31:0]            trc_pc,
  output logic [4:0]             trc_class,
  output logic [31:0]            trc_wd,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int REC_W = CNT_W + PC_W + CLASS_W + WD_W;

  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [CLASS_W-1:0] cls;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [REC_W-1:0]   wr_rec;
  logic [REC_W-1:0]   rd_rec;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               drop;

  // Class decode; the priority order matters: an all-zero word is a NOP
  // except in cycle 0, where it is the pipeline's pre-fetch garbage.
  assign opcode = ret_instr[31:26];
  assign funct  = ret_instr[5:0];

  always_comb begin
    cls = CL_UNKNOWN;
    if (ret_instr == '0 && cycle_q != '0) begin
      cls = CL_NOP;
    end else if (ret_bubble) begin
      cls = CL_BUBBLE;
    end else if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:   cls = CL_ADD;
        FN_SUB:   cls = CL_SUB;
        FN_AND:   cls = CL_AND;
        FN_OR:    cls = CL_OR;
        FN_SLT:   cls = CL_SLT;
        FN_MULTU: cls = CL_MULTU;
        FN_MFHI:  cls = CL_MFHI;
        FN_MFLO:  cls = CL_MFLO;
        FN_SRL:   cls = CL_SRL;
        default:  cls = CL_UNKNOWN;
      endcase
    end else begin
      case (opcode)
        OP_LW:    cls = CL_LW;
        OP_SW:    cls = CL_SW;
        OP_BEQ:   cls = CL_BEQ;
        OP_J:     cls = CL_J;
        OP_ADDIU: cls = CL_ADDIU;
        OP_MADDU: cls = CL_MADDU;
        default:  cls = CL_UNKNOWN;
      endcase
    end
  end

  assign wr_rec = {cycle_q, ret_pc, cls, ret_wd};

  // Push/pop decisions live here so drops are counted against the same
  // view of "full" that the FIFO uses.
  assign trc_valid = !fifo_empty;
  assign pop       = trc_valid && trc_ready;
  assign push      = ret_valid && !rst && (!fifo_full || pop);
  assign drop      = ret_valid && !rst && fifo_full && !pop;

  always_comb begin
    cycle_d = cycle_q + CNT_W'(1);
    drop_d  = drop_q;
    if (drop && drop_q != '1) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      drop_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_rec),
    .pop   (pop),
    .rdata (rd_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Fields are forced to zero while empty so nothing stale leaks out.
  always_comb begin
    trc_cycle = '0;
    trc_pc    = '0;
    trc_class = '0;
    trc_wd    = '0;
    if (trc_valid) begin
      {trc_cycle, trc_pc, trc_class, trc_wd} = rd_rec;
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_retire_trace_emitter.sv
module tb_retire_trace_emitter;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 32;
  localparam int DROP_W = 16;

  logic              clk;
  logic              rst;
  logic              ret_valid;
  logic [31:0]       ret_pc;
  logic [31:0]       ret_instr;
  logic [31:0]       ret_wd;
  logic              ret_bubble;
  logic              trc_valid;
  logic              trc_ready;
  logic [CNT_W-1:0]  trc_cycle;
  logic [31:0]       trc_pc;
  logic [4:0]        trc_class;
  logic [31:0]       trc_wd;
  logic [3:0]        fifo_level;
  logic [DROP_W-1:0] drop_count;

  int          tests_run;
  int          tests_failed;
  logic [31:0] cyc;
  logic [31:0] exp_q[$];

  retire_trace_emitter #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ret_valid  (ret_valid),
    .ret_pc     (ret_pc),
    .ret_instr  (ret_instr),
    .ret_wd     (ret_wd),
    .ret_bubble (ret_bubble),
    .trc_valid  (trc_valid),
    .trc_ready  (trc_ready),
    .trc_cycle  (trc_cycle),
    .trc_pc     (trc_pc),
    .trc_class  (trc_class),
    .trc_wd     (trc_wd),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  // cyc mirrors the DUT cycle index of the cycle now starting.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 32'd1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    ret_valid  = 1'b0;
    ret_bubble = 1'b0;
    trc_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 32'd0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ret_valid  = 1'b1;
    ret_instr  = 32'h00221820;
    ret_pc     = 32'h40;
    ret_wd     = 32'h7;
    ret_bubble = 1'b0;
    trc_ready  = 1'b0;
    tick(); tick(); tick();
    tests_run++; if (trc_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", trc_valid); end
    tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    tests_run++; if ({trc_cycle, trc_pc, trc_class, trc_wd} !== '0) begin tests_failed++; $display("FAIL reset_fields: got %0h/%0h/%0d/%0h want 0", trc_cycle, trc_pc, trc_class, trc_wd); end
    rst       = 1'b0;
    ret_valid = 1'b0;
    cyc       = 32'd0;
    tick();
    tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_ignore_push: got %0d want 0", fifo_level); end
  endtask

  task automatic test_single_add();
    int vcount;
    do_reset();
    trc_ready = 1'b1;
    repeat (3) tick();
    ret_valid  = 1'b1;
    ret_instr  = 32'h00221820;
    ret_pc     = 32'h0000_0100;
    ret_wd     = 32'd5;
    ret_bubble = 1'b0;
    tick();
    ret_valid = 1'b0;
    tests_run++; if (trc_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %0b want 1", trc_valid); end
    tests_run++; if (trc_cycle !== 32'd3) begin tests_failed++; $display("FAIL add_cycle: got %0d want 3", trc_cycle); end
    tests_run++; if (trc_class !== 5'd1) begin tests_failed++; $display("FAIL add_class: got %0d want 1", trc_class); end
    tests_run++; if (trc_wd !== 32'd5) begin tests_failed++; $display("FAIL add_wd: got %0d want 5", trc_wd); end
    tests_run++; if (trc_pc !== 32'h100) begin tests_failed++; $display("FAIL add_pc: got %0h want 100", trc_pc); end
    vcount = 0;
    repeat (4) begin
      tick();
      if (trc_valid === 1'b1) vcount++;
    end
    tests_run++; if (vcount !== 0) begin tests_failed++; $display("FAIL add_single_beat: extra valid cycles %0d want 0", vcount); end
  endtask

  task automatic test_decode();
    logic [31:0] vi [18];
    logic        vb [18];
    logic [4:0]  vc [18];
    logic [31:0] c;
    vi = '{32'h00221822, 32'h00221824, 32'h00221825, 32'h0022182A, 32'h00220019,
           32'h00001810, 32'h00001812, 32'h00021882, 32'h8C220004, 32'hAC220004,
           32'h10220003, 32'h08000010, 32'h24220001, 32'h70220001, 32'h3C010001,
           32'h00021883, 32'h00000000, 32'h8C220004};
    vb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vc = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd11, 5'd12,
           5'd13, 5'd14, 5'd15, 5'd16, 5'd31, 5'd31, 5'd0, 5'd10};
    do_reset();
    trc_ready  = 1'b1;
    ret_valid  = 1'b1;
    ret_instr  = 32'h0;
    ret_bubble = 1'b0;
    ret_pc     = 32'h0;
    ret_wd     = 32'h0;
    tick();
    tests_run++; if (trc_class !== 5'd31 || trc_cycle !== 32'd0) begin tests_failed++; $display("FAIL dec_zero_c0: got class %0d cycle %0d want 31/0", trc_class, trc_cycle); end
    ret_valid = 1'b0;
    repeat (3) tick();
    ret_valid = 1'b1;
    tick();
    tests_run++; if (trc_class !== 5'd0 || trc_cycle !== 32'd4) begin tests_failed++; $display("FAIL dec_nop_c4: got class %0d cycle %0d want 0/4", trc_class, trc_cycle); end
    ret_instr  = 32'h00000002;
    ret_bubble = 1'b1;
    tick();
    tests_run++; if (trc_class !== 5'd10) begin tests_failed++; $display("FAIL dec_bubble_srl: got %0d want 10", trc_class); end
    for (int i = 0; i < 18; i++) begin
      ret_instr  = vi[i];
      ret_bubble = vb[i];
      c = cyc;
      tick();
      tests_run++; if (trc_valid !== 1'b1 || trc_class !== vc[i] || trc_cycle !== c) begin tests_failed++; $display("FAIL dec_vec%0d: instr %0h got class %0d cycle %0d want %0d/%0d", i, vi[i], trc_class, trc_cycle, vc[i], c); end
    end
    ret_valid  = 1'b0;
    ret_bubble = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    trc_ready = 1'b0;
    ret_instr = 32'h00221820;
    for (int i = 0; i < 11; i++) begin
      ret_valid = 1'b1;
      ret_pc    = cyc;
      tick();
    end
    ret_valid = 1'b0;
    tests_run++; if (fifo_level !== 4'd8) begin tests_failed++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
    tests_run++; if (drop_count !== 16'd3) begin tests_failed++; $display("FAIL ovf_drop: got %0d want 3", drop_count); end
    trc_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests_run++; if (trc_valid !== 1'b1 || trc_cycle !== 32'(k) || trc_pc !== 32'(k)) begin tests_failed++; $display("FAIL ovf_drain%0d: got v%0b cycle %0d pc %0d want 1/%0d", k, trc_valid, trc_cycle, trc_pc, k); end
      tick();
    end
    tests_run++; if (trc_valid !== 1'b0 || fifo_level !== 4'd0) begin tests_failed++; $display("FAIL ovf_empty: got v%0b level %0d want 0/0", trc_valid, fifo_level); end
    tests_run++; if (drop_count !== 16'd3) begin tests_failed++; $display("FAIL ovf_drop_hold: got %0d want 3", drop_count); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] c;
    do_reset();
    trc_ready = 1'b0;
    ret_instr = 32'h00221820;
    for (int i = 0; i < 8; i++) begin
      ret_valid = 1'b1;
      ret_pc    = cyc;
      tick();
    end
    tests_run++; if (fifo_level !== 4'd8) begin tests_failed++; $display("FAIL fpp_fill: got %0d want 8", fifo_level); end
    ret_pc    = cyc;
    trc_ready = 1'b1;
    tick();
    ret_valid = 1'b0;
    tests_run++; if (fifo_level !== 4'd8 || drop_count !== 16'd0) begin tests_failed++; $display("FAIL fpp_level: got level %0d drop %0d want 8/0", fifo_level, drop_count); end
    for (int k = 1; k <= 8; k++) begin
      tests_run++; if (trc_valid !== 1'b1 || trc_cycle !== 32'(k)) begin tests_failed++; $display("FAIL fpp_order%0d: got v%0b cycle %0d want 1/%0d", k, trc_valid, trc_cycle, k); end
      tick();
    end
    tests_run++; if (trc_valid !== 1'b0) begin tests_failed++; $display("FAIL fpp_empty: got %0b want 0", trc_valid); end
    // One entry held, then push and pop together
    trc_ready = 1'b0;
    ret_valid = 1'b1;
    tick();
    trc_ready = 1'b1;
    c = cyc;
    tick();
    ret_valid = 1'b0;
    tests_run++; if (fifo_level !== 4'd1 || trc_cycle !== c) begin tests_failed++; $display("FAIL fpp_one: got level %0d cycle %0d want 1/%0d", fifo_level, trc_cycle, c); end
    tick();
    tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL fpp_one_drain: got %0d want 0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    logic        do_pop;
    logic        do_push;
    logic [31:0] c;
    int          popped;
    do_reset();
    exp_q.delete();
    popped    = 0;
    ret_instr = 32'h00221820;
    for (int i = 0; i < 26; i++) begin
      ret_valid = (i < 12);
      ret_pc    = cyc + 32'h1000;
      trc_ready = (i % 2 == 0);
      do_pop  = (exp_q.size() > 0) && trc_ready;
      do_push = ret_valid && ((exp_q.size() < DEPTH) || do_pop);
      c = cyc;
      tick();
      if (do_pop) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (do_push) exp_q.push_back(c);
      tests_run++; if (fifo_level !== 4'(exp_q.size()) || trc_valid !== (exp_q.size() > 0)) begin tests_failed++; $display("FAIL b2b_level%0d: got level %0d v%0b want %0d", i, fifo_level, trc_valid, exp_q.size()); end
      if (exp_q.size() > 0) begin
        tests_run++; if (trc_cycle !== exp_q[0] || trc_pc !== exp_q[0] + 32'h1000) begin tests_failed++; $display("FAIL b2b_head%0d: got cycle %0d pc %0h want %0d", i, trc_cycle, trc_pc, exp_q[0]); end
      end
    end
    tests_run++; if (popped !== 12 || drop_count !== 16'd0) begin tests_failed++; $display("FAIL b2b_total: got popped %0d drop %0d want 12/0", popped, drop_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    trc_ready = 1'b0;
    ret_instr = 32'h00221820;
    for (int i = 0; i < 5; i++) begin
      ret_valid = 1'b1;
      ret_pc    = cyc;
      tick();
    end
    tests_run++; if (fifo_level !== 4'd5) begin tests_failed++; $display("FAIL mrst_fill: got %0d want 5", fifo_level); end
    rst       = 1'b1;
    trc_ready = 1'b1;
    tick();
    tests_run++; if (trc_valid !== 1'b0 || fifo_level !== 4'd0 || drop_count !== 16'd0) begin tests_failed++; $display("FAIL mrst_clear: got v%0b level %0d drop %0d want 0/0/0", trc_valid, fifo_level, drop_count); end
    rst    = 1'b0;
    cyc    = 32'd0;
    ret_pc = 32'hABC;
    tick();
    ret_valid = 1'b0;
    tests_run++; if (trc_valid !== 1'b1 || trc_cycle !== 32'd0 || trc_pc !== 32'hABC) begin tests_failed++; $display("FAIL mrst_first: got v%0b cycle %0d pc %0h want 1/0/abc", trc_valid, trc_cycle, trc_pc); end
    tick();
    tests_run++; if (trc_valid !== 1'b0) begin tests_failed++; $display("FAIL mrst_after: got %0b want 0", trc_valid); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 32'd0;
    rst          = 1'b1;
    ret_valid    = 1'b0;
    ret_pc       = 32'h0;
    ret_instr    = 32'h0;
    ret_wd       = 32'h0;
    ret_bubble   = 1'b0;
    trc_ready    = 1'b0;
    test_reset();
    test_single_add();
    test_decode();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
